ws_frame_streamer: RTL and testbench

WS_FRAME_STREAMER -- requirements
Module: ws_frame_streamer

---
 rtl/ws_frame_streamer_if.sv | 27 ++
 rtl/ws_frame_streamer.sv | 100 ++++++++++
 tb/tb_ws_frame_streamer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ws_frame_streamer_if.sv
// Pixel-write, frame-control and encoder-handshake signals of ws_frame_streamer.
// The sequencer connects through the slave modport; the driver/encoder side uses master.
interface ws_frame_streamer_if #(
    parameter int LED_NUM = 8
);
    localparam int AW = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          frame_start;
    logic          tx_done;
    logic          tx_en;
    logic [23:0]   RGB;
    logic          busy;
    logic          frame_done;

    modport master (
        output wr_en, wr_addr, wr_data, frame_start, tx_done,
        input  tx_en, RGB, busy, frame_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, frame_start, tx_done,
        output tx_en, RGB, busy, frame_done
    );
endinterface

// File: rtl/ws_frame_streamer.sv
// Streams a pixel RAM to a WS281x bit encoder one 24-bit word at a time, then holds the latch gap.
// Optional macro WS_AUTO_REFRESH_EN restarts a frame automatically after every frame_done.
module ws_frame_streamer #(
    parameter int LED_NUM     = 8,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int LATCH_US    = 300
) (
    input logic              clk,
    input logic              rst,
    ws_frame_streamer_if.slave bus
);
    localparam int AW        = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam int LATCH_CYC = CLK_FREQ_HZ / 1_000_000 * LATCH_US;
    localparam int LCYC      = (LATCH_CYC < 1) ? 1 : LATCH_CYC;
    localparam int CW        = $clog2(LCYC + 1);

    localparam logic [AW:0]   LED_LIM  = (AW + 1)'(LED_NUM);
    localparam logic [AW-1:0] LAST_IDX = AW'(LED_NUM - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(LCYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        WAIT,
        LATCH
    } state_t;

    state_t        state, state_nxt;
    logic [23:0]   mem [LED_NUM];
    logic [AW-1:0] idx;
    logic [CW-1:0] lcnt;
    logic [23:0]   rgb_q;
    logic          fd_q;
    logic          tx_en_c;
    logic          start_c;
    logic          latch_end;

    // Pixel RAM: no reset so contents survive rst; writes accepted in every state.
    always_ff @(posedge clk) begin
        if (bus.wr_en && ({1'b0, bus.wr_addr} < LED_LIM))
            mem[bus.wr_addr] <= bus.wr_data;
    end

    assign latch_end = (state == LATCH) && (lcnt == LAST_CNT);

`ifdef WS_AUTO_REFRESH_EN
    assign start_c = bus.frame_start || fd_q;
`else
    assign start_c = bus.frame_start;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_en_c   = 1'b0;
        case (state)
            IDLE:  if (start_c) state_nxt = FETCH;
            FETCH: state_nxt = SEND;
            SEND: begin
                tx_en_c   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:  if (bus.tx_done) state_nxt = (idx == LAST_IDX) ? LATCH : FETCH;
            LATCH: if (latch_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM read sits in the FETCH register stage, so a same-cycle write is seen only next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            lcnt  <= '0;
            rgb_q <= '0;
            fd_q  <= 1'b0;
        end else begin
            if (state == IDLE)
                idx <= '0;
            else if (state == WAIT && bus.tx_done && idx != LAST_IDX)
                idx <= idx + AW'(1);

            if (state == LATCH && !latch_end) lcnt <= lcnt + CW'(1);
            else                              lcnt <= '0;

            if (state == FETCH) rgb_q <= mem[idx];

            fd_q <= latch_end;
        end
    end

    assign bus.tx_en      = tx_en_c;
    assign bus.RGB        = rgb_q;
    assign bus.busy       = (state != IDLE);
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_ws_frame_streamer.sv
// Directed bench for ws_frame_streamer (LED_NUM=4, 50 MHz, 300 us latch) with an RGB scoreboard.
module tb_ws_frame_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ws_frame_streamer_if #(.LED_NUM(4)) bus ();

    ws_frame_streamer #(
        .LED_NUM(4),
        .CLK_FREQ_HZ(50_000_000),
        .LATCH_US(300)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          errors   = 0;
    int          checks   = 0;
    int          cyc      = 0;
    int          done_cyc = -1;
    int          fd_cyc   = -1;
    int          fd_count = 0;
    int          frame_tx = 0;
    bit          resp_on  = 1'b1;
    logic        prev_tx  = 1'b0;
    logic [23:0] last_rgb = '0;
    logic [23:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [23:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick(1);
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.frame_start = 1'b1;
        tick(1);
        bus.frame_start = 1'b0;
    endtask

    task automatic push4(input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] c, input logic [23:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    task automatic wait_fd(input int target);
        int k = 0;
        while (fd_count < target && k < 20000) begin
            tick(1);
            k++;
        end
        check("frame_done_seen", 32'(fd_count >= target), 1);
    endtask

    task automatic wait_tx(input int target);
        int k = 0;
        while (frame_tx < target && k < 200) begin
            tick(1);
            k++;
        end
        check("tx_en_seen", 32'(frame_tx >= target), 1);
    endtask

    // Encoder model: tx_done one cycle wide, 10 cycles after each tx_en.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (resp_on && bus.tx_en === 1'b1) begin
                repeat (10) @(posedge clk);
                #1;
                if (resp_on) bus.tx_done = 1'b1;
                @(posedge clk);
                #1;
                bus.tx_done = 1'b0;
            end
        end
    end

    // Output monitor: pops expected RGB on every tx_en, checks gaps and latch length.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (rst) begin
                frame_tx = 0;
                prev_tx  = 1'b0;
            end else begin
                if (bus.tx_done === 1'b1) begin
                    if (bus.busy === 1'b1) check("rgb_hold", 32'(bus.RGB), 32'(last_rgb));
                    done_cyc = cyc;
                end
                if (bus.tx_en === 1'b1) begin
                    check("tx_en_single", 32'(prev_tx), 0);
                    check("tx_en_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check("rgb", 32'(bus.RGB), 32'(exp_q.pop_front()));
                    if (frame_tx > 0) check("tx_gap", 32'(cyc - done_cyc), 2);
`ifdef WS_AUTO_REFRESH_EN
                    if (frame_tx == 0 && fd_count > 0) check("auto_restart", 32'(cyc - fd_cyc), 2);
`endif
                    last_rgb = bus.RGB;
                    frame_tx++;
                end
                if (bus.frame_done === 1'b1) begin
                    fd_count++;
                    fd_cyc = cyc;
                    check("busy_at_done", 32'(bus.busy), 0);
                    // 15000 latch cycles after the last tx_done, frame_done on the next one
                    check("latch_len", 32'(cyc - done_cyc), 15001);
                    frame_tx = 0;
                end
                prev_tx = bus.tx_en;
            end
        end
    end

    initial begin
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.frame_start = 1'b0;
        bus.tx_done     = 1'b0;

        tick(3);
        check("rst_tx_en", 32'(bus.tx_en), 0);
        check("rst_rgb", 32'(bus.RGB), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_frame_done", 32'(bus.frame_done), 0);
        rst = 1'b0;
        tick(2);

        wr(2'd0, 24'h00FF00);
        wr(2'd1, 24'hFF0000);
        wr(2'd2, 24'h0000FF);
        wr(2'd3, 24'hFFFFFF);

        push4(24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFFFFFF);
`ifdef WS_AUTO_REFRESH_EN
        push4(24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFFFFFF);
`endif
        pulse_start();
        tick(1);
        check("busy_in_frame", 32'(bus.busy), 1);
        wait_fd(1);

`ifdef WS_AUTO_REFRESH_EN
        wait_fd(2);
        rst = 1'b1;
        tick(2);
        check("auto_rst_tx_en", 32'(bus.tx_en), 0);
        check("auto_rst_busy", 32'(bus.busy), 0);
        check("auto_queue_empty", 32'(exp_q.size()), 0);
        rst = 1'b0;
        tick(2);
`else
        // tx_done in IDLE must not trigger anything
        bus.tx_done = 1'b1;
        tick(1);
        bus.tx_done = 1'b0;
        tick(20);
        check("idle_tx_done_frames", 32'(fd_count), 1);
        check("idle_tx_done_busy", 32'(bus.busy), 0);

        // Frame 2: pixel 3 updated before its fetch, pixel 0 after its fetch
        push4(24'h00FF00, 24'hFF0000, 24'h0000FF, 24'h333333);
        pulse_start();
        wait_tx(2);
        tick(2);
        wr(2'd0, 24'h111111);
        wr(2'd3, 24'h333333);
        pulse_start();
        wait_fd(2);
        tick(50);
        check("no_queued_start", 32'(fd_count), 2);
        check("queue_empty_f2", 32'(exp_q.size()), 0);

        // Frame 3: reset during the WAIT of pixel 2
        exp_q.push_back(24'h111111);
        exp_q.push_back(24'hFF0000);
        exp_q.push_back(24'h0000FF);
        pulse_start();
        wait_tx(3);
        tick(3);
        resp_on = 1'b0;
        rst     = 1'b1;
        #1;
        check("abort_tx_en", 32'(bus.tx_en), 0);
        check("abort_rgb", 32'(bus.RGB), 0);
        check("abort_busy", 32'(bus.busy), 0);
        tick(2);
        rst = 1'b0;
        tick(30);
        resp_on = 1'b1;
        check("abort_no_frame_done", 32'(fd_count), 2);
        check("abort_idle", 32'(bus.busy), 0);
        check("queue_empty_f3", 32'(exp_q.size()), 0);

        // Frame 4: RAM contents survive reset
        push4(24'h111111, 24'hFF0000, 24'h0000FF, 24'h333333);
        pulse_start();
        wait_fd(3);
        tick(100);
        check("single_frame_only", 32'(fd_count), 3);
        check("queue_empty_f4", 32'(exp_q.size()), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
